// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the WISC fetch stage.
package instr_fetch_pkg;

    localparam int unsigned XLEN  = 16;
    localparam int unsigned OPC_W = 4;

    // ADD R0,R0,R0 doubles as the pipeline bubble.
    localparam logic [XLEN-1:0]  NOP_INSTR = 16'h0000;
    localparam logic [OPC_W-1:0] HLT       = 4'hF;

    typedef enum logic [1:0] {
        IF_FETCH  = 2'd0,
        IF_DRAIN  = 2'd1,
        IF_HALTED = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

    function automatic logic is_hlt(input logic [XLEN-1:0] instr);
        return instr[XLEN-1 -: OPC_W] == HLT;
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold, or flush to a bubble.
module if_id_reg
    import instr_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = IF_ID_BUBBLE;
        end else if (load_i) begin
            ifid_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= IF_ID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign data_o = ifid_q;

endmodule

// File: rtl/instr_fetch.sv
// WISC fetch stage: PC, instruction-memory address, IF/ID register and halt control.
// Optional build macro: FETCH_HLT_PREDECODE_EN (halt on the raw fetched opcode, skipping DRAIN).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        hlt_dec,
    input  logic [15:0] im_instr,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus1,
    output logic        valid_out,
    output logic        halted
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            im_rd_en_q;
    logic            halted_q;
    logic            ifid_load;
    logic            ifid_flush;
    if_id_t          ifid_in;
    if_id_t          ifid_out;

    assign ifid_in = '{instr: im_instr, pc: pc_q, valid: 1'b1};

`ifdef FETCH_HLT_PREDECODE_EN
    logic unused_hlt_dec;
    assign unused_hlt_dec = hlt_dec;
`endif

    // Next-state: redirect beats stall beats halt detection beats normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (redirect) begin
            pc_d       = redirect_pc;
            ifid_flush = 1'b1;
            state_d    = IF_FETCH;
        end else if (!stall) begin
            unique case (state_q)
                IF_FETCH: begin
`ifdef FETCH_HLT_PREDECODE_EN
                    ifid_load = 1'b1;
                    if (is_hlt(im_instr)) begin
                        state_d = IF_HALTED;
                    end else begin
                        pc_d = pc_q + XLEN'(1);
                    end
`else
                    if (hlt_dec && ifid_out.valid) begin
                        state_d = IF_DRAIN;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + XLEN'(1);
                    end
`endif
                end
                IF_DRAIN: begin
                    ifid_flush = 1'b1;
                    state_d    = IF_HALTED;
                end
                IF_HALTED: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_d = IF_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_FETCH;
            pc_q       <= RESET_PC;
            im_rd_en_q <= 1'b1;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            im_rd_en_q <= (state_d == IF_FETCH);
            halted_q   <= (state_d == IF_HALTED);
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .data_i  (ifid_in),
        .data_o  (ifid_out)
    );

    assign im_addr   = pc_q;
    assign im_rd_en  = im_rd_en_q;
    assign halted    = halted_q;
    assign instr_out = ifid_out.instr;
    assign pc_out    = ifid_out.pc;
    assign valid_out = ifid_out.valid;
    assign pc_plus1  = ifid_out.pc + XLEN'(1);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, stall, redirect, wrap, halt and halt exit.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        hlt_dec;
    logic [15:0] im_instr;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        valid_out;
    logic        halted;

    logic        hlt_en;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt_dec     (hlt_dec),
        .im_instr    (im_instr),
        .im_addr     (im_addr),
        .im_rd_en    (im_rd_en),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .valid_out   (valid_out),
        .halted      (halted)
    );

    // Memory image: opcode 1 with the low 12 address bits, HLT at 0003 once enabled.
    always_comb begin
        if (hlt_en && im_addr == 16'h0003) im_instr = 16'hF000;
        else                               im_instr = {4'h1, im_addr[11:0]};
    end

    // Decoder stand-in: HLT opcode on a valid IF/ID entry.
    assign hlt_dec = valid_out && (instr_out[15:12] == 4'hF);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt_en = 1'b0;
        #1;
        tick();
        tick();
        check("rst_im_addr",  im_addr,          16'h0000);
        check("rst_valid",    16'(valid_out),   16'h0000);
        check("rst_instr",    instr_out,        16'h0000);
        check("rst_rd_en",    16'(im_rd_en),    16'h0001);
        check("rst_halted",   16'(halted),      16'h0000);
        check("rst_pc_plus1", pc_plus1,         16'h0001);

        rst = 1'b0;
        tick();
        check("f0_instr",    instr_out,       16'h1000);
        check("f0_pc",       pc_out,          16'h0000);
        check("f0_pc_plus1", pc_plus1,        16'h0001);
        check("f0_valid",    16'(valid_out),  16'h0001);
        check("f0_im_addr",  im_addr,         16'h0001);
        for (int i = 0; i < 4; i++) tick();
        check("f4_instr",   instr_out, 16'h1004);
        check("f4_im_addr", im_addr,   16'h0005);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_im_addr", im_addr,   16'h0005);
            check("stall_instr",   instr_out, 16'h1004);
            check("stall_pc",      pc_out,    16'h0004);
        end
        stall = 1'b0;
        tick();
        check("unstall_instr",   instr_out, 16'h1005);
        check("unstall_pc",      pc_out,    16'h0005);
        check("unstall_im_addr", im_addr,   16'h0006);

        redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check("rdst_valid",   16'(valid_out), 16'h0000);
        check("rdst_instr",   instr_out,      16'h0000);
        check("rdst_im_addr", im_addr,        16'h0040);
        tick();
        check("rdst_tgt_instr", instr_out,      16'h1040);
        check("rdst_tgt_pc",    pc_out,         16'h0040);
        check("rdst_tgt_valid", 16'(valid_out), 16'h0001);

        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check("wrap_bubble",  16'(valid_out), 16'h0000);
        check("wrap_im_addr", im_addr,        16'hFFFF);
        tick();
        check("wrap_pc",       pc_out,    16'hFFFF);
        check("wrap_pc_plus1", pc_plus1,  16'h0000);
        check("wrap_instr",    instr_out, 16'h1FFF);
        check("wrap_next_pc",  im_addr,   16'h0000);
        tick();
        check("wrap_after_instr", instr_out, 16'h1000);
        check("wrap_after_pc",    pc_out,    16'h0000);

        hlt_en = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        check("h_bubble", 16'(valid_out), 16'h0000);
        for (int i = 0; i < 3; i++) tick();
        check("h_pre_instr",   instr_out, 16'h1002);
        check("h_pre_im_addr", im_addr,   16'h0003);
        tick();
        check("h_hlt_instr", instr_out,      16'hF000);
        check("h_hlt_pc",    pc_out,         16'h0003);
        check("h_hlt_valid", 16'(valid_out), 16'h0001);
`ifdef FETCH_HLT_PREDECODE_EN
        check("h_hlt_halted",  16'(halted),   16'h0001);
        check("h_hlt_im_addr", im_addr,       16'h0003);
        check("h_hlt_rd_en",   16'(im_rd_en), 16'h0000);
`else
        check("h_hlt_halted",  16'(halted),   16'h0000);
        check("h_hlt_im_addr", im_addr,       16'h0004);
        check("h_hlt_dec",     16'(hlt_dec),  16'h0001);
        tick();
        check("h_drain_halted", 16'(halted),    16'h0000);
        check("h_drain_rd_en",  16'(im_rd_en),  16'h0000);
        check("h_drain_instr",  instr_out,      16'hF000);
        check("h_drain_valid",  16'(valid_out), 16'h0001);
        check("h_drain_addr",   im_addr,        16'h0004);
        tick();
        check("h_halted",      16'(halted),    16'h0001);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("h_stay_halted", 16'(halted),    16'h0001);
            check("h_stay_rd_en",  16'(im_rd_en),  16'h0000);
            check("h_stay_valid",  16'(valid_out), 16'h0000);
            check("h_stay_instr",  instr_out,      16'h0000);
        end

        hlt_en = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        check("hx_halted",  16'(halted),    16'h0000);
        check("hx_rd_en",   16'(im_rd_en),  16'h0001);
        check("hx_valid",   16'(valid_out), 16'h0000);
        check("hx_im_addr", im_addr,        16'h0010);
        tick();
        check("hx_instr", instr_out,      16'h1010);
        check("hx_pc",    pc_out,         16'h0010);
        check("hx_valid2",16'(valid_out), 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
